eeprom_ctrl: RTL

Sequencing controller for the 2K x 8 parallel EEPROM (active-low ce_n/oe_n/we_n, 11-bit addr, shared 8-bit data bus).
- Turns a single-request valid/ready interface into correctly timed read and write strobe sequences with programmable setup, pulse, hold and access cycle counts.
- Sits between the CPU memory/loader logic and the EEPROM pins.
- The bidirectional bus is split into data_out/data_oe/data_in; the top level builds the tri-state buffer.

---
 rtl/eeprom_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/eeprom_ctrl.sv
// eeprom_ctrl: turns valid/ready requests into timed ce_n/oe_n/we_n strobe sequences for a 2K x 8 parallel EEPROM.
// Optional write read-back verify is enabled by defining EEPROM_CTRL_WR_VERIFY_EN.
module eeprom_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int READ_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in
);

  localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CD  = (HOLD_CYC > READ_CYC) ? HOLD_CYC : READ_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_CYC - 1);

`ifdef EEPROM_CTRL_WR_VERIFY_EN
  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, V_READ} state_t;
`else
  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS} state_t;
`endif

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, finish, sample;
  logic             ce_d, oe_d, we_d, drv_d;
`ifdef EEPROM_CTRL_WR_VERIFY_EN
  logic             verify;
`endif

  assign req_ready = (state == IDLE);

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt - 1'b1;
    accept  = 1'b0;
    finish  = 1'b0;
    sample  = 1'b0;
`ifdef EEPROM_CTRL_WR_VERIFY_EN
    verify  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = cnt;
        if (req_valid) begin
          accept = 1'b1;
          if (req_we) begin
            nxt     = W_SETUP;
            cnt_nxt = SETUP_LD;
          end else begin
            nxt     = R_ACCESS;
            cnt_nxt = READ_LD;
          end
        end
      end
      W_SETUP: if (cnt == '0) begin
        nxt     = W_PULSE;
        cnt_nxt = PULSE_LD;
      end
      W_PULSE: if (cnt == '0) begin
        nxt     = W_HOLD;
        cnt_nxt = HOLD_LD;
      end
      W_HOLD: if (cnt == '0) begin
`ifdef EEPROM_CTRL_WR_VERIFY_EN
        nxt     = V_READ;
        cnt_nxt = READ_LD;
`else
        nxt     = IDLE;
        finish  = 1'b1;
`endif
      end
      R_ACCESS: if (cnt == '0) begin
        nxt    = IDLE;
        finish = 1'b1;
        sample = 1'b1;
      end
`ifdef EEPROM_CTRL_WR_VERIFY_EN
      V_READ: if (cnt == '0) begin
        nxt    = IDLE;
        finish = 1'b1;
        sample = 1'b1;
        verify = 1'b1;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  // Pins are decoded from the next state and registered, so each strobe lines up with its state.
  always_comb begin
    ce_d  = 1'b1;
    oe_d  = 1'b1;
    we_d  = 1'b1;
    drv_d = 1'b0;
    case (nxt)
      W_SETUP, W_HOLD: begin
        ce_d  = 1'b0;
        drv_d = 1'b1;
      end
      W_PULSE: begin
        ce_d  = 1'b0;
        we_d  = 1'b0;
        drv_d = 1'b1;
      end
      R_ACCESS: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
      end
`ifdef EEPROM_CTRL_WR_VERIFY_EN
      V_READ: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ce_n     <= 1'b1;
      oe_n     <= 1'b1;
      we_n     <= 1'b1;
      data_oe  <= 1'b0;
      addr     <= '0;
      data_out <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      ce_n    <= ce_d;
      oe_n    <= oe_d;
      we_n    <= we_d;
      data_oe <= drv_d;
      done    <= finish;
      if (accept) addr <= req_addr;
      if (accept && req_we) data_out <= req_wdata;
      if (sample) rdata <= data_in;
`ifdef EEPROM_CTRL_WR_VERIFY_EN
      // data_out still holds the latched write data during the read-back.
      err <= verify && (data_in != data_out);
`else
      err <= 1'b0;
`endif
    end
  end

endmodule
